dhs_obi_data_arbiter: RTL and testbench
=======================================

Name: dhs_obi_data_arbiter

Overview:
2:1 arbiter that shares one OBI data port (memory/peripheral interconnect side) between the data interfaces of core_1 and core_2 in dual_helix_soc. It performs round-robin arbitration on the address phase and holds the selection until grant. An in-order ID FIFO tracks which core owns each outstanding transaction so that response-phase rvalid/rdata is returned to the correct core. It adds no cycle of latency on grant or response.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
MAX_OUTSTANDING, 4, depth of the ID FIFO; maximum number of granted-but-unanswered transactions (power of 2, >=2)

Ports:
clk_i  in  1  clock
arst_ni  in  1  asynchronous active-low reset
cN_req_i  in  1  core N request (N = 0 for core_1, N = 1 for core_2)
cN_we_i  in  1  core N write enable
cN_be_i  in  DATA_WIDTH/8  core N byte enables
cN_addr_i  in  ADDR_WIDTH  core N address
cN_wdata_i  in  DATA_WIDTH  core N write data
cN_gnt_o  out  1  core N grant
cN_rvalid_o  out  1  core N response valid
cN_rdata_o  out  DATA_WIDTH  core N read data
s_req_o  out  1  shared-port request
s_we_o  out  1  shared-port write enable
s_be_o  out  DATA_WIDTH/8  shared-port byte enables
s_addr_o  out  ADDR_WIDTH  shared-port address
s_wdata_o  out  DATA_WIDTH  shared-port write data
s_gnt_i  in  1  shared-port grant
s_rvalid_i  in  1  shared-port response valid
s_rdata_i  in  DATA_WIDTH  shared-port read data
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current FIFO occupancy
err_o  out  1  sticky protocol error

Behaviour:
- Reset (async on arst_ni low):
  - FIFO read/write pointers = 0, count = 0.
  - last_grant = 1, so core 0 wins the first tie.
  - lock = 0, err_o = 0.
  - Combinational outputs follow from this state: s_req_o = 0 when no core requests, all gnt/rvalid = 0.
- full = (count == MAX_OUTSTANDING).
- Winner selection (combinational):
  - If lock = 1: winner = locked_id.
  - Otherwise: the only requesting core; if both request, the core != last_grant.
- s_req_o = (c0_req_i | c1_req_i) & ~full & (lock ? cX_req_i of locked_id : 1).
- s_we/be/addr/wdata_o = mux of the winner's inputs. When s_req_o = 0, these outputs are don't-care; they are still driven from the winner mux.
- cN_gnt_o = s_req_o & s_gnt_i & (winner == N).
- Lock (registered): set with locked_id = winner when s_req_o & ~s_gnt_i. Cleared on handshake (s_req_o & s_gnt_i). The selection therefore never switches while a request is pending.
- last_grant <= winner on every handshake.
- ID FIFO:
  - Push winner on handshake.
  - Pop on s_rvalid_i while count > 0.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo MAX_OUTSTANDING.
- Full: s_req_o is forced low and no grant is issued. A pop in that cycle frees a slot for the next cycle only; there is no same-cycle bypass.
- Response routing: cN_rvalid_o = s_rvalid_i & (count > 0) & (head_id == N). cN_rdata_o = s_rdata_i for both cores, unconditionally.
- Response with empty FIFO (s_rvalid_i & count == 0):
  - Dropped; no core sees rvalid.
  - err_o <= 1 and stays set until reset.
- Zero added latency: grant and rvalid are combinational pass-throughs from the shared port.
- Reset mid-operation discards all outstanding IDs. Any late response then hits the empty-FIFO rule and sets err_o.
- outstanding_o = count (registered).

Test Plan:
- Single core: c0 issues a read of 0x1000_0000, slave grants immediately and returns rvalid 2 cycles later with 0xDEADBEEF -> c0_gnt_o = 1 in the request cycle; c0_rvalid_o = 1 with rdata 0xDEADBEEF; c1_gnt_o and c1_rvalid_o stay 0; outstanding_o goes 0 -> 1 -> 0.
- Both cores request continuously with s_gnt_i = 1 -> grants alternate c0, c1, c0, c1 starting with c0 after reset; responses returned in order are routed c0, c1, c0, c1.
- Both request, s_gnt_i held low for 3 cycles, then 1 -> s_addr_o stays at c0's address for all 4 cycles; c0 is granted on cycle 4 and c1 is granted on cycle 5.
- s_gnt_i = 1 with no s_rvalid_i, MAX_OUTSTANDING = 4 -> exactly 4 grants, outstanding_o = 4, then s_req_o = 0. One rvalid -> outstanding_o = 3 and s_req_o reasserts the next cycle. Same-cycle rvalid plus grant at count 3 -> count stays 3.
- s_rvalid_i pulsed with outstanding_o = 0 -> no cN_rvalid_o, err_o = 1 and held. Assert arst_ni low -> err_o = 0 and outstanding_o = 0.
- Reset asserted with 2 transactions outstanding -> outstanding_o = 0 after reset. A subsequent s_rvalid_i sets err_o and delivers no rvalid to either core.

Source files
------------

// File: rtl/dhs_obi_data_arbiter.sv
// Shares one OBI data port between two cores. The address phase is arbitrated
// round-robin, and an in-order ID FIFO routes each response back to its requester.
module dhs_obi_data_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                     clk_i,
  input  logic                                     arst_ni,
  input  logic                                     c0_req_i,
  input  logic                                     c0_we_i,
  input  logic [DATA_WIDTH/8-1:0]                  c0_be_i,
  input  logic [ADDR_WIDTH-1:0]                    c0_addr_i,
  input  logic [DATA_WIDTH-1:0]                    c0_wdata_i,
  output logic                                     c0_gnt_o,
  output logic                                     c0_rvalid_o,
  output logic [DATA_WIDTH-1:0]                    c0_rdata_o,
  input  logic                                     c1_req_i,
  input  logic                                     c1_we_i,
  input  logic [DATA_WIDTH/8-1:0]                  c1_be_i,
  input  logic [ADDR_WIDTH-1:0]                    c1_addr_i,
  input  logic [DATA_WIDTH-1:0]                    c1_wdata_i,
  output logic                                     c1_gnt_o,
  output logic                                     c1_rvalid_o,
  output logic [DATA_WIDTH-1:0]                    c1_rdata_o,
  output logic                                     s_req_o,
  output logic                                     s_we_o,
  output logic [DATA_WIDTH/8-1:0]                  s_be_o,
  output logic [ADDR_WIDTH-1:0]                    s_addr_o,
  output logic [DATA_WIDTH-1:0]                    s_wdata_o,
  input  logic                                     s_gnt_i,
  input  logic                                     s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                    s_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
  output logic                                     err_o
);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);

  logic [MAX_OUTSTANDING-1:0] id_q;
  logic [PTR_W-1:0]           rd_ptr, wr_ptr;
  logic [CNT_W-1:0]           count;
  logic                       last_grant, lock, locked_id, err;
  logic                       winner, full, empty, push, pop, locked_req, head_id;

  // A pending (ungranted) request pins the selection so the address phase stays stable.
  always_comb begin
    winner = 1'b0;
    if (lock)                        winner = locked_id;
    else if (c0_req_i && c1_req_i)   winner = ~last_grant;
    else if (c1_req_i)               winner = 1'b1;
  end

  assign full       = (count == CNT_W'(MAX_OUTSTANDING));
  assign empty      = (count == '0);
  assign locked_req = locked_id ? c1_req_i : c0_req_i;
  assign s_req_o    = (c0_req_i | c1_req_i) & ~full & (~lock | locked_req);
  assign push       = s_req_o & s_gnt_i;
  assign pop        = s_rvalid_i & ~empty;

  assign s_we_o    = winner ? c1_we_i    : c0_we_i;
  assign s_be_o    = winner ? c1_be_i    : c0_be_i;
  assign s_addr_o  = winner ? c1_addr_i  : c0_addr_i;
  assign s_wdata_o = winner ? c1_wdata_i : c0_wdata_i;

  assign c0_gnt_o = push & ~winner;
  assign c1_gnt_o = push &  winner;

  assign head_id     = id_q[rd_ptr];
  assign c0_rvalid_o = pop & ~head_id;
  assign c1_rvalid_o = pop &  head_id;
  assign c0_rdata_o  = s_rdata_i;
  assign c1_rdata_o  = s_rdata_i;

  assign outstanding_o = count;
  assign err_o         = err;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      id_q       <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      last_grant <= 1'b1;
      lock       <= 1'b0;
      locked_id  <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (s_req_o && !s_gnt_i) begin
        lock      <= 1'b1;
        locked_id <= winner;
      end else if (push) begin
        lock      <= 1'b0;
      end
      if (push) begin
        last_grant     <= winner;
        id_q[wr_ptr]   <= winner;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A response with nothing outstanding is a protocol violation; keep it visible.
      if (s_rvalid_i && empty) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dhs_obi_data_arbiter.sv
// Bench for dhs_obi_data_arbiter: directed scenarios plus random traffic, checked
// against a queue-based reference model and a response scoreboard.
module tb_dhs_obi_data_arbiter;
  localparam int MAXO = 4;

  logic              clk = 1'b0;
  logic              arst_ni;
  logic [1:0]        creq, cwe;
  logic [1:0][3:0]   cbe;
  logic [1:0][31:0]  caddr, cwdata;
  logic              sgnt, s_rvalid;
  logic [31:0]       s_rdata;
  logic              c0_gnt_o, c1_gnt_o, c0_rvalid_o, c1_rvalid_o;
  logic [31:0]       c0_rdata_o, c1_rdata_o;
  logic              s_req_o, s_we_o;
  logic [3:0]        s_be_o;
  logic [31:0]       s_addr_o, s_wdata_o;
  logic [2:0]        outstanding_o;
  logic              err_o;

  typedef struct { int core; logic [31:0] data; } resp_t;
  resp_t       exp_q[$];
  logic [31:0] slv_q[$];
  int          own_q[$];
  int          last, hold_id, total, passes;
  bit          hold, merr, fix_en;
  logic [31:0] fix_val;
  logic [1:0]  g_seen;

  always #5 clk = ~clk;

  dhs_obi_data_arbiter dut (
    .clk_i(clk), .arst_ni(arst_ni),
    .c0_req_i(creq[0]), .c0_we_i(cwe[0]), .c0_be_i(cbe[0]), .c0_addr_i(caddr[0]),
    .c0_wdata_i(cwdata[0]), .c0_gnt_o(c0_gnt_o), .c0_rvalid_o(c0_rvalid_o), .c0_rdata_o(c0_rdata_o),
    .c1_req_i(creq[1]), .c1_we_i(cwe[1]), .c1_be_i(cbe[1]), .c1_addr_i(caddr[1]),
    .c1_wdata_i(cwdata[1]), .c1_gnt_o(c1_gnt_o), .c1_rvalid_o(c1_rvalid_o), .c1_rdata_o(c1_rdata_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_addr_o(s_addr_o),
    .s_wdata_o(s_wdata_o), .s_gnt_i(sgnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else passes++;
  endtask

  // Reference model: grants are decided from the arbitration rules, outstanding
  // transactions are a plain queue of owner ids.
  initial forever begin
    int w;
    bit any, esreq, nonempty;
    logic [31:0] d;
    @(negedge clk);
    if (!arst_ni) begin
      chk("rst_sreq", s_req_o, 0);
      chk("rst_gnt", {c1_gnt_o, c0_gnt_o}, 0);
      chk("rst_rvalid", {c1_rvalid_o, c0_rvalid_o}, 0);
      chk("rst_outstanding", outstanding_o, 0);
      chk("rst_err", err_o, 0);
      hold = 0; last = 1; merr = 0; g_seen = 0;
      own_q.delete(); exp_q.delete(); slv_q.delete();
    end else begin
      any      = creq[0] | creq[1];
      nonempty = own_q.size() > 0;
      if (hold)               w = hold_id;
      else if (creq == 2'b11) w = 1 - last;
      else                    w = creq[1] ? 1 : 0;
      esreq = any && (own_q.size() < MAXO) && (!hold || creq[w]);
      chk("m_sreq", s_req_o, 64'(esreq));
      chk("m_gnt0", c0_gnt_o, 64'(esreq && sgnt && w == 0));
      chk("m_gnt1", c1_gnt_o, 64'(esreq && sgnt && w == 1));
      chk("m_rv0", c0_rvalid_o, 64'(s_rvalid && nonempty && own_q[0] == 0));
      chk("m_rv1", c1_rvalid_o, 64'(s_rvalid && nonempty && own_q[0] == 1));
      chk("m_rdata0", c0_rdata_o, s_rdata);
      chk("m_rdata1", c1_rdata_o, s_rdata);
      chk("m_outstanding", outstanding_o, 64'(own_q.size()));
      chk("m_err", err_o, 64'(merr));
      if (esreq) begin
        chk("m_addr", s_addr_o, caddr[w]);
        chk("m_we", s_we_o, cwe[w]);
        chk("m_be", s_be_o, cbe[w]);
        chk("m_wdata", s_wdata_o, cwdata[w]);
      end
      g_seen = {c1_gnt_o, c0_gnt_o};
      #2;
      if (esreq && !sgnt) begin hold = 1; hold_id = w; end
      else if (esreq) hold = 0;
      if (s_rvalid) begin
        if (nonempty) void'(own_q.pop_front());
        else merr = 1;
      end
      if (esreq && sgnt) begin
        last = w;
        own_q.push_back(w);
        d = fix_en ? fix_val : $urandom;
        exp_q.push_back('{w, d});
        slv_q.push_back(d);
      end
    end
  end

  // Response monitor: every delivered rvalid must match the oldest issued transaction.
  initial forever begin
    resp_t r;
    @(negedge clk);
    if (arst_ni && (c0_rvalid_o || c1_rvalid_o)) begin
      chk("sb_both_rvalid", c0_rvalid_o & c1_rvalid_o, 0);
      if (exp_q.size() == 0) chk("sb_unexpected_rvalid", c0_rvalid_o | c1_rvalid_o, 0);
      else begin
        r = exp_q.pop_front();
        chk("sb_core", 64'(c1_rvalid_o), 64'(r.core));
        chk("sb_data", c1_rvalid_o ? c1_rdata_o : c0_rdata_o, r.data);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic respond();
    if (slv_q.size() > 0) begin s_rvalid = 1'b1; s_rdata = slv_q.pop_front(); end
    else s_rvalid = 1'b0;
  endtask

  task automatic core_upd(input int n, input int p);
    if (creq[n] && g_seen[n]) creq[n] = 1'b0;
    if (!creq[n] && $urandom_range(99) < p) begin
      creq[n] = 1'b1; cwe[n] = 1'($urandom_range(1)); cbe[n] = 4'($urandom);
      caddr[n] = $urandom; cwdata[n] = $urandom;
    end
  endtask

  task automatic do_reset();
    step();
    arst_ni = 1'b0; creq = '0; sgnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    @(negedge clk);
    step();
    arst_ni = 1'b1;
  endtask

  initial begin
    arst_ni = 1'b0; creq = '0; cwe = '0; cbe = '0; caddr = '0; cwdata = '0;
    sgnt = 0; s_rvalid = 0; s_rdata = '0; total = 0; passes = 0; fix_en = 0; fix_val = '0;
    hold = 0; last = 1; merr = 0; g_seen = 0;

    // Single core read
    do_reset();
    step(); creq = 2'b01; caddr[0] = 32'h1000_0000; cwe[0] = 0; cbe[0] = 4'hf;
    sgnt = 1; fix_en = 1; fix_val = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t1_gnt0", c0_gnt_o, 1); chk("t1_gnt1", c1_gnt_o, 0); chk("t1_out_a", outstanding_o, 0);
    step(); creq = 0; sgnt = 0;
    @(negedge clk); chk("t1_out_b", outstanding_o, 1);
    step();
    step(); respond();
    @(negedge clk);
    chk("t1_rv0", c0_rvalid_o, 1); chk("t1_rdata", c0_rdata_o, 32'hDEAD_BEEF); chk("t1_rv1", c1_rvalid_o, 0);
    step(); s_rvalid = 0; fix_en = 0;
    @(negedge clk); chk("t1_out_c", outstanding_o, 0);

    // Both cores contend with an always-granting slave
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(); s_rvalid = 0; core_upd(0, 100); core_upd(1, 100); sgnt = 1;
      if (i >= 2) respond();
      @(negedge clk);
      chk("t2_gnt0", c0_gnt_o, 64'(i % 2 == 0));
      chk("t2_gnt1", c1_gnt_o, 64'(i % 2));
      if (i >= 2) chk("t2_rv1", c1_rvalid_o, 64'(i % 2));
    end

    // Selection held while the slave stalls
    do_reset();
    step(); creq = 2'b11; caddr[0] = 32'hA000_0000; caddr[1] = 32'hB000_0000; sgnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin step(); sgnt = (k == 3); end
      @(negedge clk);
      chk("t3_addr", s_addr_o, 32'hA000_0000);
      chk("t3_gnt0", c0_gnt_o, 64'(k == 3));
      chk("t3_gnt1", c1_gnt_o, 0);
    end
    step(); creq[0] = 0;
    @(negedge clk); chk("t3_gnt1_next", c1_gnt_o, 1); chk("t3_addr1", s_addr_o, 32'hB000_0000);

    // FIFO full and no same-cycle bypass
    do_reset();
    step(); creq = 2'b01; caddr[0] = 32'h2000_0040; sgnt = 1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      @(negedge clk);
      chk("t4_out", outstanding_o, 64'(i < 4 ? i : 4));
      chk("t4_gnt", c0_gnt_o, 64'(i < 4));
      if (i >= 4) chk("t4_full_req", s_req_o, 0);
    end
    step(); respond();
    @(negedge clk); chk("t4_nobypass", s_req_o, 0); chk("t4_pop_rv", c0_rvalid_o, 1); chk("t4_out4", outstanding_o, 4);
    step(); respond();
    @(negedge clk); chk("t4_reassert", s_req_o, 1); chk("t4_regnt", c0_gnt_o, 1); chk("t4_out3", outstanding_o, 3);
    step(); creq = 0; sgnt = 0; s_rvalid = 0;
    @(negedge clk); chk("t4_same_cycle", outstanding_o, 3);

    // Stray response sets the sticky error
    do_reset();
    step(); s_rvalid = 1; s_rdata = $urandom;
    @(negedge clk); chk("t5_rv", {c1_rvalid_o, c0_rvalid_o}, 0);
    step(); s_rvalid = 0;
    @(negedge clk); chk("t5_err", err_o, 1);
    step();
    @(negedge clk); chk("t5_err_held", err_o, 1);
    do_reset();
    @(negedge clk); chk("t5_err_clr", err_o, 0);

    // Reset with transactions in flight
    step(); creq = 2'b01; caddr[0] = 32'h3000_0000; sgnt = 1;
    step();
    step(); creq = 0; sgnt = 0;
    @(negedge clk); chk("t6_out2", outstanding_o, 2);
    do_reset();
    @(negedge clk); chk("t6_out0", outstanding_o, 0);
    step(); s_rvalid = 1; s_rdata = 32'h5555_aaaa;
    @(negedge clk); chk("t6_rv", {c1_rvalid_o, c0_rvalid_o}, 0);
    step(); s_rvalid = 0;
    @(negedge clk); chk("t6_err", err_o, 1);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(); s_rvalid = 0;
      core_upd(0, 30); core_upd(1, 30);
      sgnt = 1'($urandom_range(1));
      if ($urandom_range(99) < 40) respond();
    end
    step(); creq = 0; sgnt = 0; s_rvalid = 0;
    for (int i = 0; i < 8; i++) begin step(); respond(); end
    step(); s_rvalid = 0;
    @(negedge clk);
    chk("rnd_drained", outstanding_o, 0);
    chk("rnd_sb_empty", 64'(exp_q.size()), 0);
    chk("rnd_err", err_o, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
